md_issue_ctrl: RTL

//  E-stage scheduler for the multiply/divide unit in the 5-stage MIPS pipeline.

---
 rtl/md_issue_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - E-stage issue gate, latency tracker and stall source for the MD unit
module md_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] D_mdop,
  input  logic       D_mfhilo,
  input  logic       E_valid,
  input  logic [2:0] E_mdop,
  input  logic       flush,
  input  logic       md_busy,
  output logic [2:0] MDop_out,
  output logic       stall_md,
  output logic       busy_int,
  output logic [3:0] cycles_left,
  output logic       proto_err
);

  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  state_t state;
  logic   e_is_md;
  logic   e_is_long;
  logic   issue_ok;
  logic   start_now;
  logic   d_needs_hilo;
  logic   violation;

  // Issue decision, stall request and protocol-violation detection for the current cycle
  always_comb begin
    e_is_md      = (E_mdop != 3'd0) && (E_mdop != 3'd7);
    e_is_long    = (E_mdop >= 3'd3) && (E_mdop <= 3'd6);
    issue_ok     = E_valid && !flush && (state == IDLE) && e_is_md;
    start_now    = issue_ok && e_is_long;
    d_needs_hilo = (D_mdop != 3'd0) || D_mfhilo;
    busy_int     = (state != IDLE);
    // Combinational outputs are forced low while reset is held so the pipeline sees a quiet unit
    MDop_out     = (Reset && issue_ok) ? E_mdop : 3'd0;
    stall_md     = Reset && d_needs_hilo && (busy_int || start_now);
    violation    = (E_valid && (E_mdop != 3'd0) && (state != IDLE))
                 || (E_valid && (E_mdop == 3'd7))
                 || (busy_int != md_busy);
  end

  // Busy-window FSM: load the latency on issue, count down to idle, latch protocol errors
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      cycles_left <= 4'd0;
      proto_err   <= 1'b0;
    end else begin
      if (violation) begin
        proto_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_now) begin
            if (E_mdop <= 3'd4) begin
              state       <= RUN_MUL;
              cycles_left <= MUL_LOAD;
            end else begin
              state       <= RUN_DIV;
              cycles_left <= DIV_LOAD;
            end
          end
        end
        RUN_MUL, RUN_DIV: begin
          // The unit cannot abort, so flushes never shorten the window
          if (cycles_left <= 4'd1) begin
            state       <= IDLE;
            cycles_left <= 4'd0;
          end else begin
            cycles_left <= cycles_left - 4'd1;
          end
        end
        default: begin
          state       <= IDLE;
          cycles_left <= 4'd0;
        end
      endcase
    end
  end

endmodule
